// File: rtl/matmul_pkg.sv
// Shared types for the matmul datapath: collector FSM states and index sizing.
// No logic of its own; zero latency, no backpressure.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } rc_state_t;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int idx_len(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rc_index_counter.sv
// Row-major row/col counter pair for an n x n walk, with a last-element flag.
// Advances one step per inc; clr and reset win over inc; never stalls.
module rc_index_counter
  import matmul_pkg::*;
#(
  parameter  int n     = 8,
  localparam int N_LEN = idx_len(n)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  output logic [N_LEN:0] row,
  output logic [N_LEN:0] col,
  output logic           last
);

  localparam logic [N_LEN:0] LAST_IDX = (N_LEN + 1)'(n - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == LAST_IDX) begin
        col <= '0;
        row <= (row == LAST_IDX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == LAST_IDX) && (col == LAST_IDX);

endmodule

// File: rtl/result_collector.sv
// Gathers a row-major n x n element stream into registers, then holds it for the writer.
// Read port is combinational; in_ready is high only while filling (one element per cycle).
module result_collector
  import matmul_pkg::*;
#(
  parameter  int n     = 8,
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int N_LEN = idx_len(n)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               wr_start,
  input  logic [N_LEN:0]     wr_i,
  input  logic [N_LEN:0]     wr_j,
  output logic [WIDTH-1:0]   wr_value,
  input  logic               wr_done,
  output logic               done,
  output logic [2*N_LEN:0]   fill_count
);

  localparam int                 MEM_AW = $clog2(n * n);
  localparam int                 FC_W   = 2 * N_LEN + 1;
  localparam logic [N_LEN:0]     N_IDX  = (N_LEN + 1)'(n);
  localparam logic [FC_W-1:0]    FULL   = FC_W'(n * n);
  localparam logic [MEM_AW-1:0]  N_MUL  = MEM_AW'(n);

  rc_state_t state, state_nxt;

  logic [N_LEN:0]  row, col;
  logic            last;
  logic            accept;
  logic            clr;
  logic [MEM_AW-1:0] wr_addr, rd_addr;
  logic            rd_in_range;

  logic [WIDTH-1:0] mem [n * n];

  assign accept = in_valid && in_ready;
  assign clr    = start && ((state == ST_IDLE) || (state == ST_DONE));

  rc_index_counter #(.n(n)) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)           state_nxt = ST_FILL;
      ST_FILL:  if (accept && last)  state_nxt = ST_WRITE;
      ST_WRITE: if (wr_done)         state_nxt = ST_DONE;
      ST_DONE:  if (start)           state_nxt = ST_FILL;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_start = 1'b0;
    done     = 1'b0;
    case (state)
      ST_FILL:  in_ready = 1'b1;
      ST_WRITE: wr_start = 1'b1;
      ST_DONE:  done     = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr)                 fill_count <= '0;
    else if (accept && fill_count != FULL) fill_count <= fill_count + 1'b1;
  end

  // Storage is deliberately left uncleared by reset; only the write is gated.
  assign wr_addr = MEM_AW'(row) * N_MUL + MEM_AW'(col);

  always_ff @(posedge clk) begin
    if (rst_n && accept) mem[wr_addr] <= in_data;
  end

  assign rd_in_range = (wr_i < N_IDX) && (wr_j < N_IDX);
  assign rd_addr     = MEM_AW'(wr_i) * N_MUL + MEM_AW'(wr_j);
  assign wr_value    = rd_in_range ? mem[rd_addr] : '0;

endmodule

// File: tb/tb_result_collector.sv
// Directed-plus-random bench for result_collector (n=8) against a flat row-major model.
module tb_result_collector;

  localparam int N  = 8;
  localparam int NN = N * N;
  localparam int W  = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         wr_start;
  logic [3:0]   wr_i;
  logic [3:0]   wr_j;
  logic [W-1:0] wr_value;
  logic         wr_done;
  logic         done;
  logic [6:0]   fill_count;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_mem [NN];

  always #5 clk = ~clk;

  result_collector #(.n(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wr_start   (wr_start),
    .wr_i       (wr_i),
    .wr_j       (wr_j),
    .wr_value   (wr_value),
    .wr_done    (wr_done),
    .done       (done),
    .fill_count (fill_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        wr_i = 4'(r);
        wr_j = 4'(c);
        #1;
        chk(tag, wr_value, exp_mem[r * N + c]);
      end
    end
  endtask

  // gap_mode: 0 back-to-back, 1 idle cycle before every element, 2 random idle cycles.
  task automatic fill(input int base, input int gap_mode, input bit stray);
    logic         idle;
    logic [W-1:0] d;
    int           cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fill_entry_ready", in_ready, 1);
    chk("fill_entry_count", fill_count, 0);
    chk("fill_entry_done", done, 0);
    cnt = 0;
    for (int k = 0; k < NN; k++) begin
      idle = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
      if (idle) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        wr_done  = stray;
        step();
        wr_done  = 1'b0;
        chk("gap_count", fill_count, cnt);
        chk("gap_ready", in_ready, 1);
      end
      d        = (base != 0) ? W'(base + k) : $urandom;
      in_valid = 1'b1;
      in_data  = d;
      start    = stray && (k == NN / 3);
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      exp_mem[k] = d;
      cnt++;
      chk("fill_count", fill_count, cnt);
      if (k < NN - 1) begin
        chk("fill_ready", in_ready, 1);
        chk("fill_wr_start_low", wr_start, 0);
      end else begin
        chk("last_ready_drop", in_ready, 0);
        chk("last_wr_start_rise", wr_start, 1);
      end
    end
  endtask

  task automatic finish_write(input int hold);
    for (int h = 0; h < hold; h++) begin
      wr_done = 1'b0;
      step();
      chk("write_hold_wr_start", wr_start, 1);
      chk("write_hold_done", done, 0);
    end
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk("after_done_wr_start", wr_start, 0);
    chk("after_done_done", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    wr_i = '0; wr_j = '0; wr_done = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_start", wr_start, 0);
    chk("rst_done", done, 0);
    chk("rst_fill_count", fill_count, 0);
    rst_n = 1'b1;

    // in_valid while idle is not accepted
    in_valid = 1'b1; in_data = 32'hDEAD;
    step();
    in_valid = 1'b0;
    chk("idle_ignore_count", fill_count, 0);
    chk("idle_ignore_ready", in_ready, 0);

    // 1: back-to-back 1..64
    fill(1, 0, 1'b0);
    wr_i = 4'd2; wr_j = 4'd3; #1;
    chk("t1_mem_2_3", wr_value, 20);
    check_mem("t1_mem");
    finish_write(0);

    // 2: same stream with idle cycles, count holds at full afterwards
    fill(1, 1, 1'b0);
    for (int e = 0; e < 3; e++) begin
      in_valid = 1'b1; in_data = $urandom;
      step();
      chk("t2_count_hold", fill_count, NN);
      chk("t2_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    check_mem("t2_mem");

    // 3: wr_done held low for 10 cycles
    finish_write(10);
    chk("t3_count_in_done", fill_count, NN);

    // 4: reset after 30 accepts, reset beats a simultaneous start
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1; in_data = $urandom;
      exp_mem[k] = in_data;
      step();
    end
    in_valid = 1'b0;
    chk("t4_count_30", fill_count, 30);
    rst_n = 1'b0; start = 1'b1;
    step();
    rst_n = 1'b1; start = 1'b0;
    chk("t4_rst_ready", in_ready, 0);
    chk("t4_rst_count", fill_count, 0);
    chk("t4_rst_wr_start", wr_start, 0);
    chk("t4_rst_done", done, 0);
    fill(0, 2, 1'b0);
    check_mem("t4_mem");

    // 5: out-of-range reads, stray start/wr_done in FILL and WRITE
    wr_i = 4'd8; wr_j = 4'd0; #1;
    chk("t5_row_oob", wr_value, 0);
    wr_i = 4'd0; wr_j = 4'd9; #1;
    chk("t5_col_oob", wr_value, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("t5_write_start_ignored", wr_start, 1);
    chk("t5_write_start_count", fill_count, NN);
    finish_write(2);
    fill(0, 2, 1'b1);
    check_mem("t5_mem");
    start = 1'b1; step(); start = 1'b0;
    chk("t5_write_start_ignored2", wr_start, 1);
    finish_write(1);
    wr_done = 1'b1; step(); wr_done = 1'b0;
    chk("t5_done_wr_done_ignored", done, 1);

    // 6: refill from DONE with 101..164
    fill(101, 0, 1'b0);
    wr_i = 4'd7; wr_j = 4'd7; #1;
    chk("t6_mem_7_7", wr_value, 164);
    wr_i = 4'd0; wr_j = 4'd0; #1;
    chk("t6_mem_0_0", wr_value, 101);
    check_mem("t6_mem");
    finish_write(3);
    in_valid = 1'b1; in_data = $urandom;
    step();
    in_valid = 1'b0;
    chk("t6_done_ignore_count", fill_count, NN);
    check_mem("t6_mem_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
